// File: rtl/hdub_core_thru_pkg.sv
// Shared types and helpers for the thru-pipe core: level width, per-stage state, defaults.
package hdub_core_thru_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Beats held range over 0..2*depth; a zero-depth pipe still exposes a 1-bit level.
    function automatic int lvl_w(input int depth);
        return (depth < 1) ? 1 : $clog2(2 * depth + 1);
    endfunction

    typedef struct packed {
        logic main_valid;
        logic skid_valid;
    } stage_state_t;

endpackage

// File: rtl/hdub_core_thru_stage.sv
// One elastic stage: main register feeding downstream plus a skid register that
// absorbs the beat in flight when downstream stalls, so up_ready is purely registered.
module hdub_core_thru_stage
    import hdub_core_thru_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data
);

    stage_state_t     st_reg, st_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             up_hs, down_hs;

    assign up_ready   = !st_reg.skid_valid;
    assign down_valid = st_reg.main_valid;
    assign down_data  = main_reg;

    always_comb begin
        st_next   = st_reg;
        main_next = main_reg;
        skid_next = skid_reg;
        up_hs     = up_valid && !st_reg.skid_valid;
        down_hs   = st_reg.main_valid && down_ready;
        if (down_hs) begin
            // Skid has priority so order is preserved; up_hs is impossible while skid is full.
            if (st_reg.skid_valid) begin
                main_next          = skid_reg;
                st_next.skid_valid = 1'b0;
            end else if (up_hs) begin
                main_next = up_data;
            end else begin
                st_next.main_valid = 1'b0;
            end
        end else if (up_hs) begin
            if (!st_reg.main_valid) begin
                main_next          = up_data;
                st_next.main_valid = 1'b1;
            end else begin
                skid_next          = up_data;
                st_next.skid_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg   <= '0;
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            st_reg   <= st_next;
            main_reg <= main_next;
            skid_reg <= skid_next;
        end
    end

endmodule

// File: rtl/hdub_core_thru_pipe.sv
// WIDTH-bit valid/ready pipe of DEPTH skid stages (DEPTH=0 is a plain wire).
// Optional transfer counter enabled by defining HDUB_THRU_PIPE_COUNT_EN.
module hdub_core_thru_pipe
    import hdub_core_thru_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int COUNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [lvl_w(DEPTH)-1:0]   level
`ifdef HDUB_THRU_PIPE_COUNT_EN
    ,
    output logic [COUNT_W-1:0]        xfer_count
`endif
);

    localparam int LW = lvl_w(DEPTH);

    logic out_hs;
    assign out_hs = out_valid && out_ready;

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_valid = in_valid;
            assign in_ready  = out_ready && !rst;
            assign out_data  = in_data;
            assign level     = '0;
        end else begin : g_pipe
            logic [DEPTH:0]   vld;
            logic [DEPTH:0]   rdy;
            logic [WIDTH-1:0] dat [DEPTH+1];
            logic [LW-1:0]    level_reg;
            logic             in_hs;

            assign vld[0]     = in_valid;
            assign dat[0]     = in_data;
            assign rdy[DEPTH] = out_ready;
            assign out_valid  = vld[DEPTH];
            assign out_data   = dat[DEPTH];
            // Stages come out of reset ready; hold the producer off until reset is released.
            assign in_ready   = rdy[0] && !rst;
            assign in_hs      = in_valid && in_ready;
            assign level      = level_reg;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                hdub_core_thru_stage #(
                    .WIDTH(WIDTH)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .up_valid  (vld[gi]),
                    .up_ready  (rdy[gi]),
                    .up_data   (dat[gi]),
                    .down_valid(vld[gi+1]),
                    .down_ready(rdy[gi+1]),
                    .down_data (dat[gi+1])
                );
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    level_reg <= '0;
                end else if (in_hs && !out_hs) begin
                    level_reg <= level_reg + 1'b1;
                end else if (!in_hs && out_hs) begin
                    level_reg <= level_reg - 1'b1;
                end
            end
        end
    endgenerate

`ifdef HDUB_THRU_PIPE_COUNT_EN
    logic [COUNT_W-1:0] xfer_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_reg <= '0;
        end else if (out_hs) begin
            xfer_count_reg <= xfer_count_reg + 1'b1;
        end
    end

    assign xfer_count = xfer_count_reg;
`endif

endmodule
